// File: rtl/barrel_shifter_pkg.sv
// rtl/barrel_shifter_pkg.sv - shared encodings for the pipelined barrel shifter
package barrel_shifter_pkg;

    localparam logic [1:0] MODE_LSH = 2'b00;
    localparam logic [1:0] MODE_ASH = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_shift_stage.sv
// rtl/barrel_shift_stage.sv - one 2^STAGE shift/rotate mux with its pipeline register
module barrel_shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STAGE   = 0,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               advance,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_dir,
    input  logic [1:0]         in_mode,
    input  logic [SHAMT_W-1:0] in_shift,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_dir,
    output logic [1:0]         out_mode,
    output logic [SHAMT_W-1:0] out_shift
);

    // Fixed distance handled by this stage; always below WIDTH, so the
    // rotate terms never need a WIDTH-bit shift.
    localparam int S = 1 << STAGE;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] stage_result;

    // Shift/rotate by S for the operation's mode and direction, applied only if its shift bit is set.
    always_comb begin
        shifted = in_data;
        if (in_dir == DIR_RIGHT) begin
            case (in_mode)
                MODE_ASH: shifted = $signed(in_data) >>> S;
                MODE_ROT: shifted = (in_data >> S) | (in_data << (WIDTH - S));
                default:  shifted = in_data >> S;
            endcase
        end else begin
            // Arithmetic left and the reserved mode both fall back to a logical left shift.
            case (in_mode)
                MODE_ROT: shifted = (in_data << S) | (in_data >> (WIDTH - S));
                default:  shifted = in_data << S;
            endcase
        end
        stage_result = in_shift[STAGE] ? shifted : in_data;
    end

    // Pipeline register: loads the stage result plus the operation's control on every advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dir   <= DIR_LEFT;
            out_mode  <= MODE_LSH;
            out_shift <= '0;
        end else if (advance) begin
            out_valid <= in_valid;
            out_data  <= stage_result;
            out_dir   <= in_dir;
            out_mode  <= in_mode;
            out_shift <= in_shift;
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - pipelined logical/arithmetic/rotate barrel shifter with valid/ready
module barrel_shifter_pipe
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   IN,
    input  logic               dir,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   OUT
);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("barrel_shifter_pipe: WIDTH must be a power of two >= 2");
    end
    if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt
        $error("barrel_shifter_pipe: SHAMT_W must equal clog2(WIDTH)");
    end

    // Index 0 is the input operation; index k+1 is the register of stage k.
    logic               pipe_valid [0:SHAMT_W];
    logic [WIDTH-1:0]   pipe_data  [0:SHAMT_W];
    logic               pipe_dir   [0:SHAMT_W];
    logic [1:0]         pipe_mode  [0:SHAMT_W];
    logic [SHAMT_W-1:0] pipe_shift [0:SHAMT_W];

    logic advance;

    // The whole pipe moves together; it only stalls when a finished result is not taken.
    always_comb begin
        advance = !out_valid || out_ready;
    end

    assign in_ready      = advance;
    assign pipe_valid[0] = in_valid;
    assign pipe_data[0]  = IN;
    assign pipe_dir[0]   = dir;
    assign pipe_mode[0]  = mode;
    assign pipe_shift[0] = shift;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH   (WIDTH),
            .STAGE   (k),
            .SHAMT_W (SHAMT_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (advance),
            .in_valid  (pipe_valid[k]),
            .in_data   (pipe_data[k]),
            .in_dir    (pipe_dir[k]),
            .in_mode   (pipe_mode[k]),
            .in_shift  (pipe_shift[k]),
            .out_valid (pipe_valid[k+1]),
            .out_data  (pipe_data[k+1]),
            .out_dir   (pipe_dir[k+1]),
            .out_mode  (pipe_mode[k+1]),
            .out_shift (pipe_shift[k+1])
        );
    end

    assign out_valid = pipe_valid[SHAMT_W];
    assign OUT       = pipe_data[SHAMT_W];

    // Control fields are fully consumed by the last stage and go nowhere.
    logic unused_tail;
    assign unused_tail = ^{pipe_dir[SHAMT_W], pipe_mode[SHAMT_W], pipe_shift[SHAMT_W]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb/tb_barrel_shifter_pipe.sv - self-checking bench for barrel_shifter_pipe (WIDTH = 8)
module tb_barrel_shifter_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       dir;
    logic [1:0] mode;
    logic [2:0] shift;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    barrel_shifter_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .IN        (in_data),
        .dir       (dir),
        .mode      (mode),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .OUT       (out_data)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: whole-amount shift/rotate computed directly with integer arithmetic.
    function automatic logic [7:0] model(input logic [7:0] a, input logic d, input logic [1:0] m, input int sh);
        logic [15:0] dbl;
        int v;
        dbl = {a, a};
        if (m == 2'b10) begin
            if (d) model = 8'(dbl >> sh);
            else   model = 8'(dbl >> (8 - sh));
        end else if (m == 2'b01 && d) begin
            v = a[7] ? int'(a) - 256 : int'(a);
            v = v >>> sh;
            model = 8'(v);
        end else if (d) begin
            model = a >> sh;
        end else begin
            model = 8'(16'(a) << sh);
        end
    endfunction

    typedef struct {
        logic [7:0] mdl;
        logic [7:0] lit;
        bit         has_lit;
    } exp_t;

    exp_t       q[$];
    logic [7:0] cur_lit;
    bit         cur_has;
    bit         lat_chk = 0;
    bit         hist [8];
    int         cyc = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_out;

    // Scoreboard: records accepts, checks every consumed output, stall stability, in_ready and latency.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 8; i++) hist[i] = 0;
            prev_stall = 0;
        end else begin
            cyc++;
            if (prev_stall) begin
                check("stall_valid_hold", out_valid, 1'b1);
                check("stall_out_hold", out_data, prev_out);
            end
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (lat_chk) check("latency_pattern", out_valid, hist[(cyc + 5) % 8]);
            hist[cyc % 8] = in_valid && in_ready;
            if (in_valid && in_ready) begin
                e.mdl = model(in_data, dir, mode, int'(shift));
                e.lit = cur_lit;
                e.has_lit = cur_has;
                q.push_back(e);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_out: got 0x%0h, expected no output at %0t", out_data, $time);
                end else begin
                    e = q.pop_front();
                    check("out_vs_model", out_data, e.mdl);
                    if (e.has_lit) check("out_vs_literal", out_data, e.lit);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out = out_data;
        end
    end

    task automatic send(input logic [7:0] a, input logic d, input logic [1:0] m, input logic [2:0] s,
                        input logic [7:0] lit, input bit has);
        bit ok;
        in_data = a; dir = d; mode = m; shift = s;
        cur_lit = lit; cur_has = has;
        in_valid = 1'b1;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        int cnt;
        bit seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; dir = 1'b0; mode = 2'b00; shift = '0;
        cur_lit = '0; cur_has = 0;

        check("model_rot_r", model(8'h81, 1, 2'b10, 1), 8'hC0);
        check("model_rot_l", model(8'h81, 0, 2'b10, 3), 8'h0C);
        check("model_ash_r", model(8'h90, 1, 2'b01, 3), 8'hF2);
        check("model_lsh_r", model(8'h90, 1, 2'b00, 3), 8'h12);

        #12;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out", out_data, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 check("reset_in_ready", in_ready, 1'b1);

        // Directed vectors, back to back.
        lat_chk = 1;
        send(8'h81, 1, 2'b10, 3'd1, 8'hC0, 1);
        send(8'h81, 0, 2'b10, 3'd3, 8'h0C, 1);
        send(8'h90, 1, 2'b01, 3'd3, 8'hF2, 1);
        send(8'h90, 1, 2'b00, 3'd3, 8'h12, 1);
        send(8'h90, 0, 2'b01, 3'd1, 8'h20, 1);
        send(8'h0F, 0, 2'b00, 3'd4, 8'hF0, 1);
        for (int m = 0; m < 4; m++)
            for (int d = 0; d < 2; d++)
                send(8'hA5, d[0], m[1:0], 3'd0, 8'hA5, 1);
        send(8'h6B, 1, 2'b11, 3'd2, 8'h1A, 1);
        for (int m = 0; m < 3; m++)
            for (int d = 0; d < 2; d++)
                for (int s = 0; s < 8; s++)
                    send(8'hB6, d[0], m[1:0], s[2:0], 8'h00, 0);
        drain();

        // Backpressure: five ops, consumer stalls 4 cycles after the first result.
        lat_chk = 0;
        fork
            begin
                for (int i = 1; i <= 5; i++)
                    send(8'(i), 0, 2'b00, 3'd1, 8'(2 * i), 1);
            end
            begin
                seen = 0;
                for (int n = 0; n < 20; n++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1;
                        break;
                    end
                end
                check("bp_first_out_seen", seen, 1'b1);
                @(posedge clk); #1 out_ready = 1'b0;
                @(negedge clk);
                check("bp_in_ready_low", in_ready, 1'b0);
                check("bp_out_valid_held", out_valid, 1'b1);
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        repeat (4) @(posedge clk);
        #1;

        // Bubbles: valid pattern 1,0,1,0,... must reappear 3 cycles later.
        lat_chk = 1;
        for (int i = 0; i < 6; i++) begin
            send(8'hC3, 1, 2'b10, 3'(i + 1), 8'h00, 0);
            @(posedge clk); #1;
        end
        drain();
        repeat (4) @(posedge clk);
        #1;

        // Reset with two operations in flight.
        lat_chk = 0;
        send(8'h12, 0, 2'b00, 3'd1, 8'h24, 1);
        send(8'h34, 0, 2'b00, 3'd1, 8'h68, 1);
        @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 1'b0);
        check("midreset_out", out_data, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("post_reset_quiet", cnt, 0);
        send(8'h81, 1, 2'b10, 3'd1, 8'hC0, 1);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined successor to the team's 8-bit combinational shift/rotate unit.
- Supports logical shift, arithmetic shift and rotate, in either direction, on a WIDTH-bit word.
- One log2 mux stage per pipeline register; streams one operation per cycle under a valid/ready handshake with full backpressure.
- Sits between the operand source and the datapath consumer.

Parameters:
- WIDTH, 8, data width in bits. Must be a power of two, >= 2; elaboration error otherwise.
- SHAMT_W, $clog2(WIDTH), shift-amount width and number of pipeline stages. Derived; do not override.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input operation valid.
- in_ready  output  1  block can accept an input this cycle.
- IN  input  WIDTH  operand.
- dir  input  1  1 = right, 0 = left.
- mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved.
- shift  input  SHAMT_W  shift/rotate amount, 0..WIDTH-1.
- out_valid  output  1  OUT holds a completed result.
- out_ready  input  1  consumer accepts OUT this cycle.
- OUT  output  WIDTH  result.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits and out_valid = 0, OUT = 0, in_ready = 1 once rst_n is high. Reset mid-operation discards all in-flight operations; nothing is emitted after release until new inputs arrive.
- Pipeline structure:
  - SHAMT_W registered stages. Stage k (k = 0..SHAMT_W-1) shifts by 2^k when shift[k] = 1; otherwise it passes data through.
  - Each stage register carries data, dir, mode, the shift bits not yet consumed, and a valid bit.
  - Final stage register drives OUT / out_valid.
- Latency: an input accepted in cycle t (in_valid & in_ready) appears with out_valid = 1 in cycle t + SHAMT_W when there is no stall. WIDTH = 8 gives latency 3.
- Throughput: 1 op/cycle.
- Stall rule:
  - advance = !out_valid | out_ready; every stage updates only when advance = 1.
  - in_ready = advance (combinational, no dependency on in_valid).
  - While stalled, OUT and out_valid hold stable. Bubbles are not compressed.
- Handshake: an input is consumed only on in_valid & in_ready; an output is consumed only on out_valid & out_ready. in_valid = 0 while advancing inserts a bubble (valid 0).
- Per-stage arithmetic, shift by s = 2^k:
  - Logical left/right: zero fill.
  - Arithmetic right: fill with the operand MSB, which is sign-preserved across stages.
  - Arithmetic left: identical to logical left.
  - Rotate: bits leaving one end re-enter at the other. Rotate by 0 returns IN exactly (no WIDTH-shift term).
- Reserved mode 11 behaves as logical shift.
- shift = 0: OUT = IN for every mode and direction.
- Simultaneous events: in_valid with out_ready while full advances the pipe and accepts the input in the same cycle.
- out_ready while out_valid = 0 has no effect.
- No internal storage beyond the stage registers: no loss, no duplication, strict in-order delivery.

Decomposition:
- Package barrel_shifter_pkg: mode encodings MODE_LSH = 2'b00, MODE_ASH = 2'b01, MODE_ROT = 2'b10, MODE_RSV = 2'b11; direction constants DIR_LEFT = 0, DIR_RIGHT = 1.
- Sub-module barrel_shift_stage (params WIDTH, STAGE): one combinational 2^STAGE shift/rotate mux plus its pipeline register, advance enable and async reset. The top level instantiates SHAMT_W of these in a generate loop and derives advance / in_ready.

Test Plan (WIDTH = 8, latency 3, out_ready = 1 unless stated):
- Rotate right: IN = 0x81, dir = 1, mode = 10, shift = 1 -> OUT = 0xC0 three cycles after accept. Rotate left: IN = 0x81, shift = 3 -> OUT = 0x0C.
- Arithmetic vs logical right: IN = 0x90, dir = 1, shift = 3. Mode 01 -> OUT = 0xF2; mode 00 -> OUT = 0x12. Arithmetic left: IN = 0x90, shift = 1, mode 01 -> OUT = 0x20.
- Zero amount: IN = 0xA5, shift = 0, each mode and direction -> OUT = 0xA5. Logical left: IN = 0x0F, shift = 4 -> OUT = 0xF0.
- Backpressure: stream 5 back-to-back ops, drop out_ready for 4 cycles after the first output.
  - in_ready must drop in the same cycle.
  - OUT must hold stable while stalled.
  - All 5 results must arrive in order with no loss or duplicate.
- Bubbles: alternate in_valid 1/0 -> out_valid pattern must be the input pattern delayed by 3 cycles.
- Reset mid-flight: accept 2 ops, assert rst_n low asynchronously between clock edges.
  - Immediately: out_valid = 0, OUT = 0.
  - After release with no new input: no outputs for 10 cycles.
  - The next op then returns its correct result.
